// File: rtl/timer_unit.sv
// 8-bit down-counting timer peripheral with a power-of-eight prescaler,
// auto-reload or one-shot mode and a registered one-clock expiry interrupt.
module timer_unit #(
   parameter int PRESCALE_W = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ctrl,
   input  logic [7:0] set,
   output logic [7:0] read,
   output logic       irq
);

   logic                  en;
   logic                  ar;
   logic                  ie;
   logic                  ld;
   logic [2:0]            ps;

   logic [7:0]            count;
   logic [7:0]            count_nxt;
   logic [PRESCALE_W-1:0] prescaler;
   logic [PRESCALE_W-1:0] prescaler_nxt;
   logic                  halted;
   logic                  halted_nxt;
   logic                  irq_nxt;
   logic                  en_q;

   logic [4:0]            ps_shift;
   logic [PRESCALE_W-1:0] ps_limit;
   logic                  tick;

   assign en = ctrl[0];
   assign ar = ctrl[1];
   assign ie = ctrl[2];
   assign ps = ctrl[6:4];
   assign ld = ctrl[7];

   // Divisor is 8^PS, so the terminal prescaler value is 2^(3*PS)-1.
   assign ps_shift = 5'(ps) * 5'd3;
   assign ps_limit = (PRESCALE_W'(1) << ps_shift) - PRESCALE_W'(1);
   assign tick     = (prescaler == ps_limit);

   // Loads win over counting; any idle path parks the prescaler at zero.
   always_comb begin
      count_nxt     = count;
      prescaler_nxt = '0;
      halted_nxt    = halted;
      irq_nxt       = 1'b0;
      if (ld) begin
         count_nxt  = set;
         halted_nxt = 1'b0;
      end else if (en && !en_q) begin
         count_nxt  = set;
         halted_nxt = 1'b0;
      end else if (en && !halted) begin
         if (tick) begin
            if (count != 8'd0) begin
               count_nxt = count - 8'd1;
            end else begin
               irq_nxt = ie;
               if (ar) begin
                  count_nxt = set;
               end else begin
                  halted_nxt = 1'b1;
               end
            end
         end else begin
            prescaler_nxt = prescaler + PRESCALE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= 8'd0;
         prescaler <= '0;
         halted    <= 1'b0;
         irq       <= 1'b0;
         en_q      <= 1'b0;
      end else begin
         count     <= count_nxt;
         prescaler <= prescaler_nxt;
         halted    <= halted_nxt;
         irq       <= irq_nxt;
         en_q      <= en;
      end
   end

   // A halted one-shot always holds count at zero, so read needs no masking.
   assign read = count;

endmodule

// File: tb/tb_timer_unit.sv
// Scoreboard bench for timer_unit: expected read/irq pairs are queued per
// clock as stimulus is applied, then popped and compared after each edge.
module tb_timer_unit;

   logic       clk;
   logic       rst_n;
   logic [7:0] ctrl;
   logic [7:0] set;
   logic [7:0] read;
   logic       irq;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [7:0] rd;
      logic       iq;
   } exp_t;

   exp_t sb[$];

   timer_unit #(.PRESCALE_W(24)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .ctrl (ctrl),
      .set  (set),
      .read (read),
      .irq  (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] c, input logic [7:0] s);
      ctrl = c;
      set  = s;
   endtask

   task automatic pushExp(input string tag, input logic [7:0] rd, input logic iq, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.tag = tag;
         e.rd  = rd;
         e.iq  = iq;
         sb.push_back(e);
      end
   endtask

   // One clock per queued entry; outputs sampled 1 time unit after the edge.
   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         @(posedge clk);
         #1;
         e = sb.pop_front();
         checkOutput({e.tag, "_read"}, read, e.rd);
         checkOutput({e.tag, "_irq"}, {7'd0, irq}, {7'd0, e.iq});
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(8'h00, 8'h00);
      #12;
      checkOutput("reset_read", read, 8'h00);
      checkOutput("reset_irq", {7'd0, irq}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Disabled timer ignores set.
      applyStimulus(8'h00, 8'h05);
      pushExp("idle", 8'h00, 1'b0, 5);
      drain();

      // Auto-reload, PS=0: period of four clocks.
      applyStimulus(8'h07, 8'h03);
      pushExp("ar_a", 8'h03, 1'b0, 1);
      pushExp("ar_a", 8'h02, 1'b0, 1);
      pushExp("ar_a", 8'h01, 1'b0, 1);
      pushExp("ar_a", 8'h00, 1'b0, 1);
      pushExp("ar_exp1", 8'h03, 1'b1, 1);
      pushExp("ar_b", 8'h02, 1'b0, 1);
      pushExp("ar_b", 8'h01, 1'b0, 1);
      pushExp("ar_b", 8'h00, 1'b0, 1);
      pushExp("ar_exp2", 8'h03, 1'b1, 1);
      pushExp("ar_c", 8'h02, 1'b0, 1);
      drain();
      applyStimulus(8'h00, 8'h03);
      pushExp("ar_frozen", 8'h02, 1'b0, 2);
      drain();

      // One-shot: single irq, then halted until EN re-rises.
      applyStimulus(8'h05, 8'h02);
      pushExp("os_cnt", 8'h02, 1'b0, 1);
      pushExp("os_cnt", 8'h01, 1'b0, 1);
      pushExp("os_cnt", 8'h00, 1'b0, 1);
      pushExp("os_exp", 8'h00, 1'b1, 1);
      pushExp("os_halt", 8'h00, 1'b0, 4);
      drain();
      applyStimulus(8'h04, 8'h02);
      pushExp("os_off", 8'h00, 1'b0, 1);
      drain();
      applyStimulus(8'h05, 8'h02);
      pushExp("os_restart", 8'h02, 1'b0, 1);
      pushExp("os_restart", 8'h01, 1'b0, 1);
      drain();
      applyStimulus(8'h00, 8'h02);
      pushExp("os_frozen", 8'h01, 1'b0, 1);
      drain();

      // PS=1: decrement every 8 clocks, irq every 16.
      applyStimulus(8'h17, 8'h01);
      pushExp("ps1_load", 8'h01, 1'b0, 8);
      pushExp("ps1_zero", 8'h00, 1'b0, 8);
      pushExp("ps1_exp", 8'h01, 1'b1, 1);
      pushExp("ps1_hold", 8'h01, 1'b0, 7);
      pushExp("ps1_zero2", 8'h00, 1'b0, 1);
      drain();
      applyStimulus(8'h00, 8'h01);
      pushExp("ps1_frozen", 8'h00, 1'b0, 1);
      drain();

      // Force load mid-count; later set changes have no effect until reload.
      applyStimulus(8'h05, 8'h09);
      pushExp("ld_pre", 8'h09, 1'b0, 1);
      pushExp("ld_pre", 8'h08, 1'b0, 1);
      pushExp("ld_pre", 8'h07, 1'b0, 1);
      pushExp("ld_pre", 8'h06, 1'b0, 1);
      pushExp("ld_pre", 8'h05, 1'b0, 1);
      drain();
      applyStimulus(8'h85, 8'h09);
      pushExp("ld_pulse", 8'h09, 1'b0, 1);
      drain();
      applyStimulus(8'h05, 8'h01);
      pushExp("ld_resume", 8'h08, 1'b0, 1);
      pushExp("ld_resume", 8'h07, 1'b0, 1);
      drain();
      applyStimulus(8'h00, 8'h01);
      pushExp("ld_frozen", 8'h07, 1'b0, 1);
      drain();

      // set=0 with PS=0: back-to-back expiries.
      applyStimulus(8'h07, 8'h00);
      pushExp("b2b_load", 8'h00, 1'b0, 1);
      pushExp("b2b_exp", 8'h00, 1'b1, 3);
      drain();
      applyStimulus(8'h00, 8'h00);
      pushExp("b2b_off", 8'h00, 1'b0, 1);
      drain();

      // Asynchronous reset between edges while irq is high.
      applyStimulus(8'h07, 8'h03);
      pushExp("ar_pre", 8'h03, 1'b0, 1);
      pushExp("ar_pre", 8'h02, 1'b0, 1);
      pushExp("ar_pre", 8'h01, 1'b0, 1);
      pushExp("ar_pre", 8'h00, 1'b0, 1);
      pushExp("ar_pre_exp", 8'h03, 1'b1, 1);
      drain();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_read", read, 8'h00);
      checkOutput("async_rst_irq", {7'd0, irq}, 8'h00);
      #1;
      rst_n = 1'b1;
      pushExp("post_rst", 8'h03, 1'b0, 1);
      pushExp("post_rst", 8'h02, 1'b0, 1);
      drain();

      checkOutput("sb_empty", 8'(sb.size()), 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_unit.md
Name: timer_unit

Overview:
- Memory-mapped 8-bit down-counting timer peripheral for the CPU top level.
- The CPU drives its control byte and reload byte from write-only I/O registers and reads back the live count.
- On expiry it raises a one-clock interrupt pulse, which the CPU latches into its interrupt-pending flag.

Parameters:
- PRESCALE_W, 24, width of the internal prescaler counter. Must be at least 22 so the largest divisor, 2^21, fits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ctrl  input  8  control byte. Fields:
  - [0] EN: count enable.
  - [1] AR: auto-reload.
  - [2] IE: interrupt enable.
  - [3] reserved, ignored.
  - [6:4] PS: prescale select.
  - [7] LD: force load.
- set  input  8  reload value.
- read  output  8  current count value, driven directly from the count register.
- irq  output  1  expiry interrupt, one-clock pulse.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count=0, prescaler=0, irq=0, halted=0, en_q (registered EN)=0.
  - Reset may assert mid-count; all state clears immediately.
- Prescaler:
  - A tick occurs on the clock edge where prescaler == (1<<(3*PS))-1; prescaler then wraps to 0. Otherwise prescaler increments.
  - Divisors: PS=0 gives 1 (tick every clk), PS=1 gives 8, up to PS=7 giving 2^21.
  - The prescaler only advances while EN=1 and LD=0 and halted=0; otherwise it is held at 0.
- Load conditions, which take priority over counting:
  - LD=1: count<=set, prescaler<=0, halted<=0, no irq. Load is held every clock while LD=1.
  - EN rising edge (EN=1, en_q=0): count<=set, prescaler<=0, halted<=0.
- Counting on a tick (EN=1, LD=0, halted=0):
  - count != 0: count<=count-1.
  - count == 0 (expiry): irq<=IE for exactly one clock.
    - If AR=1, count<=set.
    - If AR=0, count stays 0 and halted<=1.
- Expiry period with AR=1 is (set+1) ticks. With set=0, expiry occurs on every tick.
- Halted state:
  - Cleared only by an LD pulse or an EN 0->1 transition.
  - While halted, read=0 and irq stays 0.
- EN=0:
  - count frozen at its current value, prescaler=0, irq=0.
  - Re-enabling reloads from set; it does not resume.
- irq is registered:
  - Asserted on the edge where expiry is detected, deasserted on the next edge unless another expiry occurs. Back-to-back expiries are possible only with PS=0 and set=0.
- Changes to set while counting have no effect until the next reload.
- PS changes while counting take effect on the next prescaler compare; no restart.
- read updates on the same edge as count (zero added latency beyond the register).
- en_q <= EN every clock.

Test Plan:
- Reset, then ctrl=0x00, set=0x05 -> read=0x00 and irq=0 indefinitely.
- set=3, ctrl=0x07 (EN, AR, IE, PS=0):
  - First edge with EN high loads 3.
  - read then steps 3,2,1,0 on successive clocks.
  - irq pulses one clock when count is 0, then reload to 3. Period 4 clocks, repeating.
- set=2, ctrl=0x05 (EN, IE, one-shot) -> read counts 2,1,0, one irq pulse, then halted: read stays 0 with no further irq. Toggling EN 0->1 reloads 2 and restarts.
- set=1, ctrl=0x17 (PS=1) -> count decrements every 8 clocks; irq every 16 clocks.
- During counting, assert rst_n=0 between clock edges -> read and irq go to 0 immediately without a clock edge.
- Mid-count at read=5 with set=9, pulse ctrl[7]=1 for 1 clock -> read=9 next edge, no irq. Countdown resumes from 9.
